// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Writeback arbiter for the common data bus (CDB). The functional units
// (0=add, 1=mul, 2=div, 3=br, 4=mem) offer completed results over a
// valid/ready handshake. At most one result is granted per cycle. The winner's
// payload is registered and broadcast one cycle later to the RAT, the physical
// register file, the reservation stations and the ROB.
//
// Grant selection:
//   default                  round-robin; rr_ptr names the highest-priority
//                            requester and moves to winner+1 after each grant.
//   CDB_ARB_FIXED_PRIO_EN    when this macro is defined, fixed priority is
//                            used instead (mem > br > div > mul > add) and
//                            there is no rr_ptr. Starvation is possible.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   global_branch_signal  branch flush; suppresses this cycle's grant
//   req_valid[i]          requester i offers a result
//   req_ready[i]          requester i is granted this cycle (one-hot or zero,
//                         combinational)
//   req_rd/pd/data/rob_idx[i]  payload of requester i
//   cdb_valid             registered broadcast valid (one cycle per grant)
//   cdb_regf_we           cdb_valid && cdb_rd != 0
//   cdb_rd/pd/data/rob_idx  registered broadcast payload (held between grants)
//   cdb_src               index of the requester that produced the broadcast
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_REQ       = 5,
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       global_branch_signal,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [4:0]                 req_rd      [NUM_REQ],
  input  logic [PHYS_REG_BITS-1:0]   req_pd      [NUM_REQ],
  input  logic [31:0]                req_data    [NUM_REQ],
  input  logic [ROB_IDX_BITS-1:0]    req_rob_idx [NUM_REQ],
  output logic                       cdb_valid,
  output logic                       cdb_regf_we,
  output logic [4:0]                 cdb_rd,
  output logic [PHYS_REG_BITS-1:0]   cdb_pd,
  output logic [31:0]                cdb_data,
  output logic [ROB_IDX_BITS-1:0]    cdb_rob_idx,
  output logic [$clog2(NUM_REQ)-1:0] cdb_src
);

  localparam int SRC_W = $clog2(NUM_REQ);

  logic             grant_any;
  logic [SRC_W-1:0] grant_idx;

`ifndef CDB_ARB_FIXED_PRIO_EN
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] rr_ptr_next;
`endif

  // Winner selection. Reset and flush both force "no grant", which keeps
  // req_ready low and blocks capture and pointer movement in one place.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
`ifdef CDB_ARB_FIXED_PRIO_EN
    // Ascending scan: the last valid index seen is the highest one, which is
    // the highest-priority requester.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'(i);
      end
    end
`else
    // Scan rr_ptr, rr_ptr+1, ... with wrap-around; first valid wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx[SRC_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[SRC_W-1:0];
      end
    end
`endif
    if (rst || global_branch_signal) begin
      grant_any = 1'b0;
      grant_idx = '0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

`ifndef CDB_ARB_FIXED_PRIO_EN
  // Pointer moves just past the winner so it becomes lowest priority next.
  always_comb begin
    if (grant_idx == SRC_W'(NUM_REQ - 1)) rr_ptr_next = '0;
    else                                   rr_ptr_next = grant_idx + SRC_W'(1);
  end
`endif

  // Output register. Payload holds between grants; only cdb_valid pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      cdb_valid   <= 1'b0;
      cdb_regf_we <= 1'b0;
      cdb_rd      <= '0;
      cdb_pd      <= '0;
      cdb_data    <= '0;
      cdb_rob_idx <= '0;
      cdb_src     <= '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
      rr_ptr      <= '0;
`endif
    end else begin
      cdb_valid   <= grant_any;
      // Results to x0 are still broadcast (the ROB needs them) but must not
      // write the register file.
      cdb_regf_we <= grant_any && (req_rd[grant_idx] != 5'd0);
      if (grant_any) begin
        cdb_rd      <= req_rd[grant_idx];
        cdb_pd      <= req_pd[grant_idx];
        cdb_data    <= req_data[grant_idx];
        cdb_rob_idx <= req_rob_idx[grant_idx];
        cdb_src     <= grant_idx;
`ifndef CDB_ARB_FIXED_PRIO_EN
        rr_ptr      <= rr_ptr_next;
`endif
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Writeback arbiter sharing the single common data bus (CDB) among the out-of-order core's functional units (add, mul, div, br, mem). It accepts at most one completed result per cycle over a valid/ready handshake and broadcasts it, registered, to the RAT, the physical register file, the reservation stations and the ROB. It discards all pending grants on a branch flush (`global_branch_signal`).

## Interface
- `NUM_REQ`, default 5: number of requesters; index 0=add, 1=mul, 2=div, 3=br, 4=mem.
- `PHYS_REG_BITS`, default 6: physical register tag width.
- `ROB_IDX_BITS`, default 5: ROB index width.
- `clk` input, 1: clock. One clock domain.
- `rst` input, 1: synchronous, active-high reset.
- `global_branch_signal` input, 1: flush. Kills this cycle's grant.
- `req_valid[NUM_REQ]` input, 1 each: requester i has a result.
- `req_ready[NUM_REQ]` output, 1 each: requester i is granted this cycle.
- `req_rd[NUM_REQ]` input, 5 each: architectural destination.
- `req_pd[NUM_REQ]` input, PHYS_REG_BITS each: physical destination.
- `req_data[NUM_REQ]` input, 32 each: result value.
- `req_rob_idx[NUM_REQ]` input, ROB_IDX_BITS each: ROB entry.
- `cdb_valid` output, 1: broadcast valid.
- `cdb_regf_we` output, 1: `cdb_valid && cdb_rd != 0`.
- `cdb_rd`, `cdb_pd`, `cdb_data`, `cdb_rob_idx` output, widths as above: broadcast payload.
- `cdb_src` output, $clog2(NUM_REQ): index of the granted requester.

## Operation
- Handshake:
  - A transfer occurs on a cycle where `req_valid[i] && req_ready[i]`.
  - A requester holds valid and payload stable until it is granted, or until a flush.
  - `req_ready` is one-hot or zero.
  - `req_ready[i]` is combinational from all `req_valid`, the priority state and `global_branch_signal`.
- Grant selection in round-robin mode (default):
  - A pointer `rr_ptr` names the highest-priority index.
  - Search runs `rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …` with wrap-around. The first valid requester wins.
  - On a grant to i, `rr_ptr` becomes `(i+1) mod NUM_REQ`. With no grant, `rr_ptr` holds.
- Flush: when `global_branch_signal` is 1, all `req_ready` are 0, no capture occurs, and `rr_ptr` holds. Requesters drop their in-flight results themselves.
- Output register:
  - On a grant, the winner's payload and index are captured and `cdb_valid` goes to 1 for exactly one cycle.
  - With no grant, `cdb_valid` is 0 and the payload registers hold their last values.
- Results with `rd=0` are granted and broadcast normally, with `cdb_regf_we=0`. The ROB still needs these results.
- Reset values: `cdb_valid=0`, `cdb_regf_we=0`, `cdb_rd=0`, `cdb_pd=0`, `cdb_data=0`, `cdb_rob_idx=0`, `cdb_src=0`, `rr_ptr=0`. `req_ready` is all 0 while `rst` is high.
- Reset mid-operation: a captured but not yet broadcast result is lost and `cdb_valid` is 0 the next cycle. Requesters are reset by the same `rst`.

## Timing
- Grant in cycle T: the broadcast is visible in cycle T+1, a latency of 1. Throughput is one result per cycle.
- Back-to-back grants to different requesters produce consecutive `cdb_valid` cycles with no bubble.
- A flush in cycle T: `cdb_valid=0` in T+1. A broadcast already registered in T (granted in T-1) is still presented in T; the consumers apply their own flush priority.
- The worst-case wait for any valid requester is NUM_REQ-1 cycles in round-robin mode.

## Configuration
- `CDB_ARB_FIXED_PRIO_EN`:
  - Defined: round-robin is replaced by fixed priority, mem(4) > br(3) > div(2) > mul(1) > add(0). `rr_ptr` is not implemented. Starvation is permitted.
  - Undefined: round-robin exactly as above.

## Test plan
- Reset, then all `req_valid=0` for 3 cycles → `cdb_valid=0` and all outputs 0 every cycle.
- Single requester, mul with `rd=5`, `pd=37`, `data=0xDEADBEEF`, `rob=9` in cycle T → `req_ready[1]=1` in T; in T+1 `cdb_valid=1`, `cdb_regf_we=1`, `cdb_src=1`, payload matches; in T+2 `cdb_valid=0`.
- All 5 requesters valid and held from reset (round-robin) → grant order 0,1,2,3,4 on consecutive cycles and `cdb_valid=1` for 5 consecutive cycles. With `CDB_ARB_FIXED_PRIO_EN` → order 4,3,2,1,0.
- Wrap-around: after a grant to index 4, requesters 0 and 3 valid → 0 is granted first, then 3.
- `rd=0` result from add → `cdb_valid=1` and `cdb_regf_we=0` next cycle.
- Flush: `global_branch_signal=1` with requesters 1 and 2 valid → `req_ready=0` and `cdb_valid=0` next cycle, `rr_ptr` unchanged. After the flush, `rst` asserted with a capture pending → `cdb_valid=0` the following cycle.
